// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the dual-core DataMemory port arbiter: FSM states,
// owner encoding and the word-alignment check.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic CORE0 = 1'b0;
  localparam logic CORE1 = 1'b1;

  localparam logic [1:0] ALIGN_MASK = 2'b00;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != ALIGN_MASK;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin winner select: on a tie the core that did not own
// the previous transaction wins.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req0 | req1;
    winner  = CORE0;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = CORE1;
    end
  end

endmodule

// File: rtl/dmem_dual_arbiter.sv
// Shares one DataMemory read/write port between two cores, one transaction
// in flight at a time, round-robin between simultaneous requesters.
module dmem_dual_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              err0,
  output logic              err1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              stall0,
  output logic              stall1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  state_t              state_q, state_d;
  logic                last_owner_q, last_owner_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                winner;
  logic                any_req;

  rr_arbiter2 u_rr_arbiter2 (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // Outputs are registered, so the ISSUE-cycle strobes are computed on the
  // IDLE->ISSUE transition and the rvalid strobe on the WAIT->RESP transition.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    err_d        = '0;
    rvalid_d     = '0;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d      = winner;
          last_owner_d = winner;
          we_d         = (winner == CORE1) ? we1    : we0;
          mem_addr_d   = (winner == CORE1) ? addr1  : addr0;
          mem_wdata_d  = (winner == CORE1) ? wdata1 : wdata0;
          gnt_d[winner] = 1'b1;
          if (is_misaligned(mem_addr_d[1:0])) begin
            err_d[winner] = 1'b1;
          end else if (we_d) begin
            mem_we_d = 1'b1;
          end else begin
            mem_re_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_misaligned(mem_addr_q[1:0]) || we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == CORE1) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
          rvalid_d[owner_q] = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= CORE1;
      owner_q      <= CORE0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      err_q        <= '0;
      rvalid_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      err_q        <= err_d;
      rvalid_q     <= rvalid_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;

  assign stall0 = req0 & ~gnt_q[0];
  assign stall1 = req1 & ~gnt_q[1];

endmodule

// File: tb/tb_dmem_dual_arbiter.sv
// Self-checking bench for dmem_dual_arbiter: table of single transactions
// checked through an event scoreboard, plus contention, latency and reset sequences.
module tb_dmem_dual_arbiter;

  localparam int RD_LAT_A = 1;
  localparam int RD_LAT_B = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A (RD_LAT = 1)
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1, stall0, stall1;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, busy;

  // DUT B (RD_LAT = 3)
  logic        b_req0, b_req1, b_we0, b_we1;
  logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
  logic        b_gnt0, b_gnt1, b_err0, b_err1, b_rvalid0, b_rvalid1, b_stall0, b_stall1;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_we, b_mem_re, b_busy;

  dmem_dual_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT_A)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .stall0(stall0), .stall1(stall1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  dmem_dual_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT_B)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .err0(b_err0), .err1(b_err1),
    .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .stall0(b_stall0), .stall1(b_stall1),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory model for DUT A: one-cycle read latency; unwritten words read a fixed pattern.
  logic [31:0] mem [0:63];
  bit          written [0:63];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return (a[7:2] == 6'd8) ? 32'hCAFE_F00D : {16'h5500, 8'h00, 2'b00, a[7:2]};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]]     <= mem_wdata;
      written[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_re) begin
      mem_rdata <= written[mem_addr[7:2]] ? mem[mem_addr[7:2]] : default_word(mem_addr);
    end
  end

  // DUT B sees a value that changes every cycle so the capture cycle is visible.
  assign b_mem_rdata = 32'h1000_0000 + cyc;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h cycle=%0d", name, got, exp, cyc);
    end
  endtask

  // Scoreboard of expected grant / response events
  typedef struct {
    bit          is_rv;
    bit          core;
    int          cyc;
    logic [1:0]  err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } ev_t;

  ev_t         sbq[$];
  ev_t         mev;
  logic [31:0] hold [2];

  function automatic ev_t mk_ev(input bit is_rv, input bit core, input int c, input logic [1:0] err,
                                input bit we, input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] r);
    ev_t e;
    e.is_rv = is_rv; e.core = core; e.cyc = c; e.err = err;
    e.we = we; e.addr = a; e.wdata = w; e.rdata = r;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold[0] = '0;
      hold[1] = '0;
    end else begin
      chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
        if (sbq.size() == 0) begin
          chk("gnt_unexpected", 32'd1, 32'd0);
        end else begin
          mev = sbq.pop_front();
          chk("gnt_kind", {31'd0, mev.is_rv}, 32'd0);
          chk("gnt_core", {30'd0, gnt1, gnt0}, mev.core ? 32'd2 : 32'd1);
          chk("gnt_cycle", cyc, mev.cyc);
          chk("gnt_err", {30'd0, err1, err0}, {30'd0, mev.err});
          chk("gnt_mem_we", {31'd0, mem_we}, {31'd0, mev.we && mev.err == 2'b00});
          chk("gnt_mem_re", {31'd0, mem_re}, {31'd0, !mev.we && mev.err == 2'b00});
          chk("gnt_mem_addr", mem_addr, mev.addr);
          if (mev.we) chk("gnt_mem_wdata", mem_wdata, mev.wdata);
          chk("gnt_busy", {31'd0, busy}, 32'd1);
        end
      end else begin
        chk("no_gnt_strobes", {28'd0, err1, err0, mem_we, mem_re}, 32'd0);
      end
      if (rvalid0 || rvalid1) begin
        if (sbq.size() == 0) begin
          chk("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          mev = sbq.pop_front();
          chk("rv_kind", {31'd0, mev.is_rv}, 32'd1);
          chk("rv_core", {30'd0, rvalid1, rvalid0}, mev.core ? 32'd2 : 32'd1);
          chk("rv_cycle", cyc, mev.cyc);
          chk("rv_rdata", mev.core ? rdata1 : rdata0, mev.rdata);
          chk("rv_other_rdata", mev.core ? rdata0 : rdata1, hold[!mev.core]);
          hold[mev.core] = mev.rdata;
        end
      end else begin
        chk("rdata0_hold", rdata0, hold[0]);
        chk("rdata1_hold", rdata1, hold[1]);
      end
    end
  end

  task automatic drive(input bit core, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] w);
    if (core) begin
      req1 = r; we1 = we; addr1 = a; wdata1 = w;
    end else begin
      req0 = r; we0 = we; addr0 = a; wdata0 = w;
    end
  endtask

  typedef struct {
    bit          core;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic run_txn(input vec_t v);
    int  t;
    int  n;
    bit  seen;
    @(posedge clk); #1;
    drive(v.core, 1'b1, v.we, v.addr, v.wdata);
    t = cyc;
    sbq.push_back(mk_ev(1'b0, v.core, t + 1, v.exp_err, v.we, v.addr, v.wdata, '0));
    if (!v.we && v.exp_err == 2'b00)
      sbq.push_back(mk_ev(1'b1, v.core, t + 2 + RD_LAT_A, 2'b00, 1'b0, v.addr, '0, v.exp_rdata));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = v.core ? gnt1 : gnt0;
      if (!seen) chk("stall_pending", {31'd0, v.core ? stall1 : stall0}, 32'd1);
      n++;
    end
    chk("gnt_seen", {31'd0, seen}, 32'd1);
    chk("stall_at_gnt", {31'd0, v.core ? stall1 : stall0}, 32'd0);
    chk("stall_other", {31'd0, v.core ? stall0 : stall1}, 32'd0);
    @(posedge clk); #1;
    drive(v.core, 1'b0, 1'b0, '0, '0);
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sbq.size(), 32'd0);
    @(negedge clk);
    chk("busy_idle_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic core_proc(input bit core, input int k);
    int  n;
    bit  seen;
    for (int i = 0; i < k; i++) begin
      drive(core, 1'b1, 1'b1, (core ? 32'h44 : 32'h40) + 32'(8 * i),
            (core ? 32'hB000_0000 : 32'hA000_0000) + 32'(i));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 12) begin
        @(negedge clk);
        seen = core ? gnt1 : gnt0;
        if (!seen) chk("dual_stall_pending", {31'd0, core ? stall1 : stall0}, 32'd1);
        n++;
      end
      chk("dual_gnt_seen", {31'd0, seen}, 32'd1);
      chk("dual_stall_at_gnt", {31'd0, core ? stall1 : stall0}, 32'd0);
      @(posedge clk); #1;
    end
    drive(core, 1'b0, 1'b0, '0, '0);
  endtask

  // Both cores request continuously; grants must alternate starting with core 0.
  task automatic dual_run(input int k);
    int t;
    int n;
    @(posedge clk); #1;
    t = cyc;
    for (int i = 0; i < k; i++) begin
      sbq.push_back(mk_ev(1'b0, 1'b0, t + 1 + 4 * i, 2'b00, 1'b1, 32'h40 + 32'(8 * i),
                          32'hA000_0000 + 32'(i), '0));
      sbq.push_back(mk_ev(1'b0, 1'b1, t + 3 + 4 * i, 2'b00, 1'b1, 32'h44 + 32'(8 * i),
                          32'hB000_0000 + 32'(i), '0));
    end
    fork
      core_proc(1'b0, k);
      core_proc(1'b1, k);
    join
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("dual_sb_drained", sbq.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 32'd0);
    chk({tag, "_err"},    {30'd0, err1, err0}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    chk({tag, "_mem_en"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    chk({tag, "_stall"},  {30'd0, stall1, stall0}, 32'd0);
    chk({tag, "_rdata0"}, rdata0, 32'd0);
    chk({tag, "_rdata1"}, rdata1, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;

    vecs[0] = '{core: 1'b0, we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF, exp_err: 2'b00, exp_rdata: 32'h0};
    vecs[1] = '{core: 1'b1, we: 1'b0, addr: 32'h20, wdata: 32'h0,         exp_err: 2'b00, exp_rdata: 32'hCAFE_F00D};
    vecs[2] = '{core: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_err: 2'b00, exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{core: 1'b1, we: 1'b0, addr: 32'h22, wdata: 32'h0,         exp_err: 2'b10, exp_rdata: 32'h0};
    vecs[4] = '{core: 1'b1, we: 1'b1, addr: 32'h24, wdata: 32'h1234_5678, exp_err: 2'b00, exp_rdata: 32'h0};
    vecs[5] = '{core: 1'b0, we: 1'b0, addr: 32'h24, wdata: 32'h0,         exp_err: 2'b00, exp_rdata: 32'h1234_5678};
    vecs[6] = '{core: 1'b0, we: 1'b1, addr: 32'h11, wdata: 32'h0BAD_BAD0, exp_err: 2'b01, exp_rdata: 32'h0};
    vecs[7] = '{core: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0,         exp_err: 2'b00, exp_rdata: 32'hDEAD_BEEF};

    #12;
    check_reset_outputs("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    dual_run(2);

    // RD_LAT = 3 on the second instance
    @(posedge clk); #1;
    b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 32'h30;
    t = cyc;
    @(negedge clk);
    chk("lat3_no_early_gnt", {31'd0, b_gnt1}, 32'd0);
    @(negedge clk);
    chk("lat3_gnt", {31'd0, b_gnt1}, 32'd1);
    chk("lat3_mem_re", {31'd0, b_mem_re}, 32'd1);
    chk("lat3_mem_addr", b_mem_addr, 32'h30);
    @(posedge clk); #1;
    b_req1 = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("lat3_no_early_rvalid", {31'd0, b_rvalid1}, 32'd0);
      chk("lat3_busy_wait", {31'd0, b_busy}, 32'd1);
      chk("lat3_mem_re_once", {31'd0, b_mem_re}, 32'd0);
    end
    @(negedge clk);
    chk("lat3_rvalid_cycle", {31'd0, b_rvalid1}, 32'd1);
    chk("lat3_rvalid_at", cyc, t + 2 + RD_LAT_B);
    chk("lat3_rdata", b_rdata1, 32'h1000_0000 + 32'(t + 4));
    chk("lat3_rdata0_untouched", b_rdata0, 32'd0);
    @(negedge clk);
    chk("lat3_idle_after", {31'd0, b_busy}, 32'd0);
    chk("lat3_rvalid_pulse", {31'd0, b_rvalid1}, 32'd0);

    // Reset in the middle of a load on DUT A
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
    t = cyc;
    sbq.push_back(mk_ev(1'b0, 1'b0, t + 1, 2'b00, 1'b0, 32'h20, '0, '0));
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("mid_load_busy", {31'd0, busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("post_reset_idle", {31'd0, busy}, 32'd0);
    end
    chk("post_reset_sb_empty", sbq.size(), 32'd0);

    dual_run(1);

    repeat (2) @(negedge clk);
    chk("final_sb_empty", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
